// File: rtl/vehicle_detector.sv
// Synchronises and debounces the loop sensor into the TLC car-present request X.
// Adds a post-departure hold, counts vehicles (saturating), and keeps X high on a stuck sensor.
module vehicle_detector #(
  parameter int DEBOUNCE    = 4,
  parameter int HOLD        = 3,
  parameter int STUCK_LIMIT = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sensor_raw,
  output logic             X,
  output logic [CNT_W-1:0] vehicle_count,
  output logic             fault,
  output logic             fault_seen
);

  localparam int MAX_AB = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int MAXP   = (MAX_AB > STUCK_LIMIT) ? MAX_AB : STUCK_LIMIT;
  localparam int CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_LIMIT - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUAL_ON  = 3'd1,
    ST_PRESENT  = 3'd2,
    ST_QUAL_OFF = 3'd3,
    ST_HOLD     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  state_t           state_q;
  logic             sync1_q, sync2_q;
  logic [CW-1:0]    dcnt_q, hcnt_q, pcnt_q;
  logic             x_q, fault_q, fault_seen_q;
  logic [CNT_W-1:0] count_q;
  logic             s_in;

  assign s_in = sync2_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= ST_IDLE;
      dcnt_q       <= '0;
      hcnt_q       <= '0;
      pcnt_q       <= '0;
      x_q          <= 1'b0;
      fault_q      <= 1'b0;
      fault_seen_q <= 1'b0;
      count_q      <= '0;
    end else begin
      sync1_q <= sensor_raw;
      sync2_q <= sync1_q;
      case (state_q)
        ST_IDLE: begin
          if (s_in) begin
            state_q <= ST_QUAL_ON;
            dcnt_q  <= ONE;
          end
        end
        ST_QUAL_ON: begin
          if (!s_in) begin
            state_q <= ST_IDLE;
          end else if (dcnt_q == DEB_LAST) begin
            state_q <= ST_PRESENT;
            x_q     <= 1'b1;
            pcnt_q  <= '0;
            if (count_q != '1) count_q <= count_q + 1'b1;
          end else begin
            dcnt_q <= dcnt_q + ONE;
          end
        end
        ST_PRESENT: begin
          if (!s_in) begin
            state_q <= ST_QUAL_OFF;
            dcnt_q  <= ONE;
          end else if (pcnt_q == STUCK_LAST) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_seen_q <= 1'b1;
            dcnt_q       <= '0;
          end else begin
            pcnt_q <= pcnt_q + ONE;
          end
        end
        // A returning signal here is the same vehicle, so pcnt is not restarted.
        ST_QUAL_OFF: begin
          if (s_in) begin
            state_q <= ST_PRESENT;
          end else if (dcnt_q == DEB_LAST) begin
            state_q <= ST_HOLD;
            hcnt_q  <= '0;
          end else begin
            dcnt_q <= dcnt_q + ONE;
          end
        end
        ST_HOLD: begin
          if (s_in) begin
            state_q <= ST_PRESENT;
            pcnt_q  <= '0;
          end else if (hcnt_q == HOLD_LAST) begin
            state_q <= ST_IDLE;
            x_q     <= 1'b0;
          end else begin
            hcnt_q <= hcnt_q + ONE;
          end
        end
        // dcnt here counts consecutive low cycles; any high sample restarts it.
        ST_FAULT: begin
          if (s_in) begin
            dcnt_q <= '0;
          end else if (dcnt_q == DEB_LAST) begin
            state_q <= ST_HOLD;
            hcnt_q  <= '0;
            fault_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          x_q     <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign X             = x_q;
  assign vehicle_count = count_q;
  assign fault         = fault_q;
  assign fault_seen    = fault_seen_q;

endmodule

// File: tb/tb_vehicle_detector.sv
// Bench for vehicle_detector: expected X edges are queued when the sensor is driven
// and consumed by a monitor when X actually changes.
module tb_vehicle_detector;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       sensor_raw = 1'b0;
  logic       X, X2;
  logic [7:0] vehicle_count;
  logic [1:0] count2;
  logic       fault, fault_seen, fault2, fault_seen2;

  vehicle_detector dut (
    .clock(clock), .clear(clear), .sensor_raw(sensor_raw),
    .X(X), .vehicle_count(vehicle_count), .fault(fault), .fault_seen(fault_seen)
  );

  vehicle_detector #(.CNT_W(2)) dut2 (
    .clock(clock), .clear(clear), .sensor_raw(sensor_raw),
    .X(X2), .vehicle_count(count2), .fault(fault2), .fault_seen(fault_seen2)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    bit x;
    int cnt;
  } ev_t;

  ev_t  ev_q[$];
  ev_t  mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_cnt  = 0;
  bit   mon_en   = 1'b0;
  logic x_prev   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Every X change must match the oldest queued expectation in cycle, value and count.
  always @(negedge clock) begin
    if (mon_en && X !== x_prev) begin
      n_checks++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL x_edge: X went %0b at cycle %0d, required no change", X, cyc);
      end else begin
        mon_e = ev_q.pop_front();
        if (X !== mon_e.x || cyc != mon_e.cyc || vehicle_count !== 8'(mon_e.cnt)) begin
          n_fail++;
          $display("FAIL x_edge: X=%0b cycle=%0d count=%0d, required X=%0b cycle=%0d count=%0d",
                   X, cyc, vehicle_count, mon_e.x, mon_e.cyc, mon_e.cnt);
        end
      end
    end
    x_prev = X;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_edge(input int dly, input bit x);
    ev_t e;
    e.cyc = cyc + dly;
    e.x   = x;
    e.cnt = exp_cnt;
    ev_q.push_back(e);
  endtask

  // One qualified vehicle: rise 6 edges after driving high, fall 9 edges after driving low.
  task automatic vehicle(input int hi);
    exp_cnt++;
    sensor_raw = 1'b1;
    push_edge(6, 1'b1);
    tick(hi);
    sensor_raw = 1'b0;
    push_edge(9, 1'b0);
    tick(12);
  endtask

  task automatic test_reset;
    #1 clear = 1'b0;
    #1;
    n_checks++;
    if (X !== 1'b0 || vehicle_count !== 8'd0 || fault !== 1'b0 || fault_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: X=%0b cnt=%0d fault=%0b seen=%0b, required all 0",
               X, vehicle_count, fault, fault_seen);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      sensor_raw = ~sensor_raw;
      #2;
      n_checks++;
      if (X !== 1'b0 || vehicle_count !== 8'd0 || fault !== 1'b0 || fault_seen !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: X=%0b cnt=%0d fault=%0b seen=%0b, required all 0",
                 X, vehicle_count, fault, fault_seen);
      end
    end
    @(negedge clock);
    sensor_raw = 1'b1;
    clear      = 1'b1;
    mon_en     = 1'b1;
    exp_cnt    = 1;
    push_edge(6, 1'b1);
    tick(10);
    sensor_raw = 1'b0;
    push_edge(9, 1'b0);
    tick(12);
    n_checks++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_release_edges: %0d edges missing, required 0", ev_q.size());
      ev_q.delete();
    end
  endtask

  task automatic test_bounce;
    for (int r = 0; r < 5; r++) begin
      sensor_raw = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (i == 3) sensor_raw = 1'b0;
        tick(1);
        n_checks++;
        if (X !== 1'b0) begin
          n_fail++;
          $display("FAIL bounce_x: X=%0b at cycle %0d, required 0", X, cyc);
        end
      end
    end
    sensor_raw = 1'b0;
    tick(8);
    n_checks++;
    if (vehicle_count !== 8'(exp_cnt) || X !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_count: cnt=%0d X=%0b, required cnt=%0d X=0", vehicle_count, X, exp_cnt);
    end
  endtask

  task automatic test_clean_vehicle;
    vehicle(20);
    n_checks++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL clean_edges: %0d edges missing, required 0", ev_q.size());
      ev_q.delete();
    end
    n_checks++;
    if (vehicle_count !== 8'(exp_cnt) || X !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_count: cnt=%0d X=%0b, required cnt=%0d X=0", vehicle_count, X, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    exp_cnt++;
    sensor_raw = 1'b1;
    push_edge(6, 1'b1);
    tick(10);
    // Second car is first sampled on the 7th edge after departure: still inside the hold.
    sensor_raw = 1'b0;
    tick(6);
    sensor_raw = 1'b1;
    base = exp_cnt;
    tick(10);
    sensor_raw = 1'b0;
    push_edge(9, 1'b0);
    tick(15);
    n_checks++;
    if (vehicle_count !== 8'(base)) begin
      n_fail++;
      $display("FAIL retrigger_count: cnt=%0d, required %0d", vehicle_count, base);
    end
    exp_cnt++;
    sensor_raw = 1'b1;
    push_edge(6, 1'b1);
    tick(10);
    sensor_raw = 1'b0;
    push_edge(9, 1'b0);
    tick(12);
    n_checks++;
    if (ev_q.size() != 0 || vehicle_count !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL late_arrival: %0d edges missing cnt=%0d, required 0 missing cnt=%0d",
               ev_q.size(), vehicle_count, exp_cnt);
      ev_q.delete();
    end
  endtask

  task automatic test_stuck;
    exp_cnt++;
    sensor_raw = 1'b1;
    push_edge(6, 1'b1);
    tick(69);
    n_checks++;
    if (fault !== 1'b0 || fault_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_early: fault=%0b seen=%0b, required 0 0", fault, fault_seen);
    end
    tick(1);
    n_checks++;
    if (fault !== 1'b1 || fault_seen !== 1'b1 || X !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_entry: fault=%0b seen=%0b X=%0b, required 1 1 1", fault, fault_seen, X);
    end
    tick(30);
    sensor_raw = 1'b0;
    push_edge(9, 1'b0);
    tick(5);
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_exit_early: fault=%0b, required 1", fault);
    end
    tick(1);
    n_checks++;
    if (fault !== 1'b0 || X !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_exit: fault=%0b X=%0b, required fault=0 X=1", fault, X);
    end
    tick(6);
    n_checks++;
    if (fault_seen !== 1'b1 || fault !== 1'b0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL stuck_sticky: seen=%0b fault=%0b missing=%0d, required 1 0 0",
               fault_seen, fault, ev_q.size());
      ev_q.delete();
    end
  endtask

  task automatic test_saturation;
    int exp2;
    @(negedge clock);
    mon_en = 1'b0;
    clear  = 1'b0;
    #1;
    n_checks++;
    if (vehicle_count !== 8'd0 || count2 !== 2'd0 || fault_seen !== 1'b0 ||
        fault_seen2 !== 1'b0 || fault2 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_reset: cnt=%0d cnt2=%0d seen=%0b seen2=%0b fault2=%0b, required all 0",
               vehicle_count, count2, fault_seen, fault_seen2, fault2);
    end
    @(negedge clock);
    clear   = 1'b1;
    mon_en  = 1'b1;
    exp_cnt = 0;
    tick(2);
    for (int k = 1; k <= 5; k++) begin
      vehicle(10);
      exp2 = (k > 3) ? 3 : k;
      n_checks++;
      if (count2 !== 2'(exp2)) begin
        n_fail++;
        $display("FAIL sat_count2: after %0d cars cnt=%0d, required %0d", k, count2, exp2);
      end
    end
    n_checks++;
    if (vehicle_count !== 8'd5 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL sat_count8: cnt=%0d missing=%0d, required 5 0", vehicle_count, ev_q.size());
      ev_q.delete();
    end
    exp_cnt++;
    sensor_raw = 1'b1;
    push_edge(6, 1'b1);
    tick(9);
    n_checks++;
    if (ev_q.size() != 0 || X !== 1'b1) begin
      n_fail++;
      $display("FAIL present_before_clear: X=%0b missing=%0d, required X=1 0", X, ev_q.size());
      ev_q.delete();
    end
    mon_en = 1'b0;
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if (X !== 1'b0 || vehicle_count !== 8'd0 || X2 !== 1'b0 || count2 !== 2'd0) begin
      n_fail++;
      $display("FAIL clear_in_present: X=%0b cnt=%0d X2=%0b cnt2=%0d, required all 0",
               X, vehicle_count, X2, count2);
    end
    @(negedge clock);
    sensor_raw = 1'b0;
    clear      = 1'b1;
    tick(4);
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_bounce;
    test_clean_vehicle;
    test_back_to_back;
    test_stuck;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vehicle_detector.md
Name: vehicle_detector

Overview:
Conditioning stage directly upstream of the traffic light controller (TLC). Takes the raw, asynchronous, bouncy country-road loop-sensor signal and synchronises and debounces it. It produces the clean car-present request X that the TLC consumes, with a post-departure hold (gap extension). It also counts qualified vehicles and flags a stuck sensor, failing safe by keeping X asserted.

Parameters:
DEBOUNCE, 4, consecutive synchronised cycles needed to accept a level change (min 2)
HOLD, 3, cycles X stays high after a departure is qualified (min 1)
STUCK_LIMIT, 64, consecutive PRESENT cycles after which the sensor is declared stuck
CNT_W, 8, width of vehicle counter

Ports:
clock  in  1  system clock, rising-edge
clear  in  1  asynchronous active-low reset (clear=0 resets)
sensor_raw  in  1  raw loop detector, asynchronous to clock
X  out  1  registered car-present request to TLC
vehicle_count  out  CNT_W  qualified arrivals, saturating
fault  out  1  high while in FAULT state
fault_seen  out  1  sticky; set on entry to FAULT, cleared only by reset

Behaviour:
- Reset (clear=0, async): sync flops=0, state=IDLE, all counters=0, X=0, vehicle_count=0, fault=0, fault_seen=0.
- s_in = sensor_raw through 2-flop synchroniser. All decisions use s_in only.
- Single debounce counter dcnt, hold counter hcnt, presence counter pcnt. Width: ceil(log2(max param)) + 1.
- X, fault, fault_seen, vehicle_count are registers updated on the same edge as the state.
- States and transitions:
  - IDLE (X=0): s_in=1 -> QUAL_ON, dcnt=1.
  - QUAL_ON (X=0): s_in=0 -> IDLE. s_in=1 and dcnt==DEBOUNCE-1 -> PRESENT, pcnt=0, vehicle_count+1 (saturate at 2^CNT_W-1). Otherwise dcnt+1.
  - PRESENT (X=1): s_in=0 -> QUAL_OFF, dcnt=1. Else pcnt+1; pcnt==STUCK_LIMIT-1 -> FAULT.
  - QUAL_OFF (X=1): s_in=1 -> PRESENT (pcnt continues, no count). s_in=0 and dcnt==DEBOUNCE-1 -> HOLD, hcnt=0. Otherwise dcnt+1.
  - HOLD (X=1): s_in=1 -> PRESENT, pcnt=0, no new count (same vehicle/platoon). hcnt==HOLD-1 -> IDLE. Otherwise hcnt+1.
  - FAULT (X=1, fault=1): s_in=0 for DEBOUNCE consecutive cycles -> HOLD, hcnt=0, fault=0. Any s_in=1 restarts dcnt.
- Latency:
  - Rise: X goes 1 on the (DEBOUNCE+2)th rising edge after sensor_raw is first sampled high and held.
  - Fall: X goes 0 DEBOUNCE+2+HOLD edges after sensor_raw is sampled low and held.
  - Defaults: 6 and 9 cycles.
- Glitches shorter than DEBOUNCE synchronised cycles never change X or vehicle_count.
- Reset asserted mid-operation: immediate return to reset values regardless of state. Count is lost.
- Illegal state encoding -> IDLE on next edge.

Test Plan:
- Reset: clear=0 with sensor_raw=1 toggling -> X=0, vehicle_count=0, fault=0, fault_seen=0 throughout. Release clear -> first X rise exactly 6 edges after sensor_raw sampled high.
- Bounce reject: sensor_raw pulses 1 for 3 cycles, 0 for 2, repeated 5 times -> X stays 0, vehicle_count=0.
- Clean vehicle: sensor_raw=1 for 20 cycles then 0 -> X rises on edge 6 after rise, falls on edge 9 after fall, vehicle_count=1.
- Re-trigger in HOLD: second vehicle arrives 7 cycles after the first leaves -> X never drops, vehicle_count stays 1. Arrival 15 cycles after -> X drops, then rises again, vehicle_count=2.
- Stuck sensor: sensor_raw=1 for 100 cycles -> fault=1 and fault_seen=1 after PRESENT reaches 64 cycles, X stays 1. sensor_raw=0 -> fault=0 after 4 synchronised low cycles, X=0 after 3 further hold cycles, fault_seen stays 1.
- Saturation and reset: CNT_W=2, 5 clean vehicles -> vehicle_count=3. Assert clear while in PRESENT -> X=0 and vehicle_count=0 immediately, without waiting for a clock edge.
